// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants, sequencer state encoding, PC width default
// and the opcode classifier used by the instruction decoder.
package cpu_pkg;

  localparam int unsigned PcWDefault = 6;

  localparam logic [3:0] OpNop = 4'h0;
  localparam logic [3:0] OpMov = 4'h1;
  localparam logic [3:0] OpAdd = 4'h2;
  localparam logic [3:0] OpSub = 4'h3;
  localparam logic [3:0] OpAnd = 4'h4;
  localparam logic [3:0] OpOr  = 4'h5;
  localparam logic [3:0] OpXor = 4'h6;
  localparam logic [3:0] OpNot = 4'h7;
  localparam logic [3:0] OpJmp = 4'h8;
  localparam logic [3:0] OpJz  = 4'h9;
  localparam logic [3:0] OpHlt = 4'hF;

  typedef enum logic [2:0] {
    StFetch     = 3'd0,
    StDecode    = 3'd1,
    StExecute   = 3'd2,
    StWriteback = 3'd3,
    StHalt      = 3'd4
  } state_e;

  typedef enum logic [2:0] {
    InstrNop = 3'd0,
    InstrAlu = 3'd1,
    InstrJmp = 3'd2,
    InstrJz  = 3'd3,
    InstrHlt = 3'd4
  } instr_class_e;

  // Reserved opcodes 1010-1110 fall through to NOP.
  function automatic instr_class_e classify(logic [3:0] op);
    instr_class_e cls;
    case (op)
      OpMov, OpAdd, OpSub, OpAnd, OpOr, OpXor, OpNot: cls = InstrAlu;
      OpJmp:   cls = InstrJmp;
      OpJz:    cls = InstrJz;
      OpHlt:   cls = InstrHlt;
      default: cls = InstrNop;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/control_sequencer_decoder.sv
// Instruction decoder: splits a 10-bit instruction word into opcode, register fields,
// jump target and instruction class.
module control_sequencer_decoder
  import cpu_pkg::*;
(
  input  logic [9:0]   instr_i,
  output logic [3:0]   opcode_o,
  output logic [2:0]   dest_o,
  output logic [2:0]   src_o,
  output logic [5:0]   target_o,
  output instr_class_e iclass_o
);

  assign opcode_o = instr_i[9:6];
  assign dest_o   = instr_i[5:3];
  assign src_o    = instr_i[2:0];
  assign target_o = instr_i[5:0];
  assign iclass_o = classify(instr_i[9:6]);

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXECUTE/WRITEBACK/HALT.
// Optional retired-instruction counter and port enabled by macro RETIRE_CNT_EN.
module control_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned PC_W = PcWDefault
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [9:0]      instr,
  input  logic            instr_valid,
  input  logic            zero_flag,
  output logic [PC_W-1:0] pc,
  output logic            fetch_req,
  output logic [2:0]      rd_addr_a,
  output logic [2:0]      rd_addr_b,
  output logic [3:0]      alu_op,
  output logic [2:0]      wr_addr,
  output logic            reg_we,
  output logic            halted
`ifdef RETIRE_CNT_EN
  ,
  output logic [15:0]     retire_cnt
`endif
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [9:0]      ir_q, ir_d;

  logic [3:0]      ir_opcode;
  logic [2:0]      ir_dest, ir_src;
  logic [5:0]      ir_target;
  instr_class_e    ir_class;
  logic [PC_W-1:0] pc_inc;

  control_sequencer_decoder u_decoder (
    .instr_i  (ir_q),
    .opcode_o (ir_opcode),
    .dest_o   (ir_dest),
    .src_o    (ir_src),
    .target_o (ir_target),
    .iclass_o (ir_class)
  );

  assign pc_inc = pc_q + PC_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StFetch;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  // Outputs decode from state so an asynchronous reset drops reg_we in the same cycle.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    fetch_req = 1'b0;
    rd_addr_a = '0;
    rd_addr_b = '0;
    alu_op    = OpNop;
    wr_addr   = '0;
    reg_we    = 1'b0;
    halted    = 1'b0;
    unique case (state_q)
      StFetch: begin
        fetch_req = 1'b1;
        if (instr_valid) begin
          ir_d    = instr;
          state_d = StDecode;
        end
      end
      StDecode: begin
        rd_addr_a = ir_dest;
        rd_addr_b = ir_src;
        state_d   = StExecute;
      end
      StExecute: begin
        rd_addr_a = ir_dest;
        rd_addr_b = ir_src;
        state_d   = StFetch;
        case (ir_class)
          InstrAlu: begin
            alu_op  = ir_opcode;
            state_d = StWriteback;
          end
          InstrJmp: pc_d    = PC_W'(ir_target);
          InstrJz:  pc_d    = zero_flag ? PC_W'(ir_target) : pc_inc;
          InstrHlt: state_d = StHalt;
          default:  pc_d    = pc_inc;
        endcase
      end
      StWriteback: begin
        reg_we  = 1'b1;
        wr_addr = ir_dest;
        alu_op  = ir_opcode;
        pc_d    = pc_inc;
        state_d = StFetch;
      end
      StHalt: halted = 1'b1;
      default: state_d = StFetch;
    endcase
  end

  assign pc = pc_q;

`ifdef RETIRE_CNT_EN
  logic [15:0] retire_q, retire_d;
  logic        retire_inc;

  // Non-ALU ops (HLT included) retire leaving EXECUTE; ALU ops retire in WRITEBACK.
  assign retire_inc = ((state_q == StExecute) && (ir_class != InstrAlu)) ||
                      (state_q == StWriteback);

  always_comb begin
    retire_d = retire_q;
    if (retire_inc) begin
      retire_d = retire_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retire_q <= '0;
    end else begin
      retire_q <= retire_d;
    end
  end

  assign retire_cnt = retire_q;
`endif

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer with a per-instruction reference model.
module tb_control_sequencer;

  localparam int unsigned PCW = 6;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [9:0]     instr = '0;
  logic           instr_valid = 1'b0;
  logic           zero_flag = 1'b0;
  logic [PCW-1:0] pc;
  logic           fetch_req;
  logic [2:0]     rd_addr_a, rd_addr_b, wr_addr;
  logic [3:0]     alu_op;
  logic           reg_we, halted;
`ifdef RETIRE_CNT_EN
  logic [15:0]    retire_cnt;
`endif

  control_sequencer #(.PC_W(PCW)) dut (
    .clk         (clk),
    .reset       (reset),
    .instr       (instr),
    .instr_valid (instr_valid),
    .zero_flag   (zero_flag),
    .pc          (pc),
    .fetch_req   (fetch_req),
    .rd_addr_a   (rd_addr_a),
    .rd_addr_b   (rd_addr_b),
    .alu_op      (alu_op),
    .wr_addr     (wr_addr),
    .reg_we      (reg_we),
    .halted      (halted)
`ifdef RETIRE_CNT_EN
    ,
    .retire_cnt  (retire_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Architectural model: program counter, halted flag, retired count.
  int m_pc = 0;
  bit m_halted = 1'b0;
  int m_retire = 0;

  task automatic check_retire(input string name);
`ifdef RETIRE_CNT_EN
    logic [15:0] exp_r;
    exp_r = 16'(m_retire);
    n_cmp++;
    if (retire_cnt !== exp_r) begin
      n_fail++;
      $display("FAIL %s retire_cnt: got %0d expected %0d", name, retire_cnt, exp_r);
    end
`else
    if (name.len() < 0) $display("%s", name);
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    instr_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    m_pc = 0;
    m_halted = 1'b0;
    m_retire = 0;
  endtask

  // Runs one instruction starting at a negedge with the DUT in FETCH; ends at the
  // negedge after the instruction completes.
  task automatic exec_instr(input logic [9:0] w, input logic zf, input int wait_cyc,
                            input string name);
    logic [3:0]     op;
    logic [3:0]     exp_alu;
    logic [PCW-1:0] exp_pc;
    bit             is_alu;
    op = w[9:6];
    is_alu = (op >= 4'd1) && (op <= 4'd7);
    exp_alu = is_alu ? op : 4'd0;
    zero_flag = zf;
    instr = 10'($urandom);
    instr_valid = 1'b0;
    for (int i = 0; i < wait_cyc; i++) begin
      exp_pc = PCW'(m_pc);
      n_cmp++;
      if (fetch_req !== 1'b1 || pc !== exp_pc || reg_we !== 1'b0) begin
        n_fail++;
        $display("FAIL %s stall: fetch_req=%0b pc=%0d reg_we=%0b expected 1/%0d/0",
                 name, fetch_req, pc, reg_we, exp_pc);
      end
      @(negedge clk);
    end
    instr = w;
    instr_valid = 1'b1;
    exp_pc = PCW'(m_pc);
    n_cmp++;
    if (fetch_req !== 1'b1 || pc !== exp_pc) begin
      n_fail++;
      $display("FAIL %s fetch: fetch_req=%0b pc=%0d expected 1/%0d", name, fetch_req, pc, exp_pc);
    end
    @(negedge clk);
    // Garbage on the fetch interface must not disturb the latched instruction.
    instr_valid = 1'($urandom);
    instr = 10'($urandom);
    n_cmp++;
    if (fetch_req !== 1'b0 || rd_addr_a !== w[5:3] || rd_addr_b !== w[2:0] ||
        reg_we !== 1'b0 || alu_op !== 4'd0) begin
      n_fail++;
      $display("FAIL %s decode: freq=%0b a=%0d b=%0d we=%0b alu=%0h expected 0/%0d/%0d/0/0",
               name, fetch_req, rd_addr_a, rd_addr_b, reg_we, alu_op, w[5:3], w[2:0]);
    end
    @(negedge clk);
    n_cmp++;
    if (fetch_req !== 1'b0 || rd_addr_a !== w[5:3] || rd_addr_b !== w[2:0] ||
        reg_we !== 1'b0 || alu_op !== exp_alu) begin
      n_fail++;
      $display("FAIL %s execute: freq=%0b a=%0d b=%0d we=%0b alu=%0h expected 0/%0d/%0d/0/%0h",
               name, fetch_req, rd_addr_a, rd_addr_b, reg_we, alu_op, w[5:3], w[2:0], exp_alu);
    end
    if (is_alu) begin
      @(negedge clk);
      n_cmp++;
      if (reg_we !== 1'b1 || wr_addr !== w[5:3] || alu_op !== op || fetch_req !== 1'b0) begin
        n_fail++;
        $display("FAIL %s writeback: we=%0b wr=%0d alu=%0h freq=%0b expected 1/%0d/%0h/0",
                 name, reg_we, wr_addr, alu_op, fetch_req, w[5:3], op);
      end
    end
    if (op == 4'hF) begin
      m_halted = 1'b1;
    end else if (op == 4'h8 || (op == 4'h9 && zf)) begin
      m_pc = w[5:0] % (1 << PCW);
    end else begin
      m_pc = (m_pc + 1) % (1 << PCW);
    end
    m_retire++;
    @(negedge clk);
    instr_valid = 1'b0;
    exp_pc = PCW'(m_pc);
    n_cmp++;
    if (halted !== m_halted || fetch_req !== !m_halted || pc !== exp_pc || reg_we !== 1'b0) begin
      n_fail++;
      $display("FAIL %s next: halted=%0b freq=%0b pc=%0d we=%0b expected %0b/%0b/%0d/0",
               name, halted, fetch_req, pc, reg_we, m_halted, !m_halted, exp_pc);
    end
    check_retire(name);
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (fetch_req !== 1'b1 || pc !== '0 || halted !== 1'b0 || reg_we !== 1'b0 ||
        alu_op !== 4'd0 || rd_addr_a !== 3'd0 || rd_addr_b !== 3'd0 || wr_addr !== 3'd0) begin
      n_fail++;
      $display("FAIL reset: freq=%0b pc=%0d halt=%0b we=%0b alu=%0h a=%0d b=%0d wr=%0d expected 1/0/0/0/0/0/0/0",
               fetch_req, pc, halted, reg_we, alu_op, rd_addr_a, rd_addr_b, wr_addr);
    end
    check_retire("reset");
  endtask

  task automatic test_mov();
    exec_instr(10'b0001_010_011, 1'b0, 0, "mov");
  endtask

  task automatic test_fetch_stall();
    exec_instr(10'b0010_001_100, 1'b0, 5, "stall");
  endtask

  task automatic test_jz();
    exec_instr(10'b1001_101010, 1'b1, 1, "jz_taken");
    exec_instr(10'b1001_000111, 1'b0, 0, "jz_not_taken");
  endtask

  task automatic test_wrap();
    exec_instr(10'b1000_111111, 1'b0, 0, "jmp63");
    exec_instr(10'b0000_000000, 1'b0, 0, "nop_wrap");
    exec_instr(10'b1000_111111, 1'b1, 0, "jmp63b");
    exec_instr(10'b1100_101101, 1'b1, 2, "undef_wrap");
  endtask

  task automatic test_random();
    logic [9:0] w;
    for (int i = 0; i < 40; i++) begin
      w = 10'($urandom);
      if (w[9:6] == 4'hF) w[9:6] = 4'h2;
      exec_instr(w, 1'($urandom), int'($urandom_range(0, 3)), "random");
    end
  endtask

  task automatic test_halt();
    logic [PCW-1:0] exp_pc;
    exec_instr(10'b1111_000000, 1'b0, 0, "hlt");
    exp_pc = PCW'(m_pc);
    for (int i = 0; i < 20; i++) begin
      instr_valid = ~instr_valid;
      instr = 10'($urandom);
      @(negedge clk);
      n_cmp++;
      if (halted !== 1'b1 || fetch_req !== 1'b0 || reg_we !== 1'b0 || pc !== exp_pc) begin
        n_fail++;
        $display("FAIL halt_hold: halted=%0b freq=%0b we=%0b pc=%0d expected 1/0/0/%0d",
                 halted, fetch_req, reg_we, pc, exp_pc);
      end
    end
    check_retire("halt_hold");
    do_reset();
    n_cmp++;
    if (halted !== 1'b0 || pc !== '0 || fetch_req !== 1'b1) begin
      n_fail++;
      $display("FAIL halt_reset: halted=%0b pc=%0d freq=%0b expected 0/0/1", halted, pc, fetch_req);
    end
  endtask

  task automatic test_reset_mid();
    exec_instr(10'b1000_010100, 1'b0, 0, "mid_jmp");
    instr = 10'b0010_011_001;
    instr_valid = 1'b1;
    repeat (3) @(negedge clk);
    instr_valid = 1'b0;
    n_cmp++;
    if (reg_we !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_wb: reg_we=%0b expected 1", reg_we);
    end
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if (reg_we !== 1'b0 || pc !== '0 || fetch_req !== 1'b1 || alu_op !== 4'd0 ||
        wr_addr !== 3'd0) begin
      n_fail++;
      $display("FAIL mid_reset: we=%0b pc=%0d freq=%0b alu=%0h wr=%0d expected 0/0/1/0/0",
               reg_we, pc, fetch_req, alu_op, wr_addr);
    end
    @(negedge clk);
    reset = 1'b0;
    m_pc = 0;
    m_halted = 1'b0;
    m_retire = 0;
    check_retire("mid_reset");
    exec_instr(10'b0011_100_010, 1'b0, 0, "cnt1");
    exec_instr(10'b0000_000000, 1'b0, 1, "cnt2");
    exec_instr(10'b1001_000101, 1'b1, 0, "cnt3");
    do_reset();
    check_retire("cnt_reset");
  endtask

  initial begin
    test_reset();
    test_mov();
    test_fetch_stall();
    test_jz();
    test_wrap();
    test_random();
    test_reset_mid();
    test_halt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
